// File: rtl/clk_en_seq.sv
`default_nettype none
// ============================================================================
// Module      : clk_en_seq
// Description : PLL lock supervisor, system reset sequencer and NUM_CH
//               phase-aligned clock-enable generators with glitch-free
//               run-time divide-ratio updates.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_en_seq #(
    parameter int                       NUM_CH       = 3,
    parameter int                       DIV_W        = 8,
    parameter logic [NUM_CH*DIV_W-1:0]  DIV_INIT     = {8'd27, 8'd10, 8'd5},
    parameter int                       LOCK_SYNC    = 2,
    parameter int                       LOCK_STABLE  = 1024,
    parameter int                       LOCK_TIMEOUT = 65536,
    parameter int                       PLL_RST_LEN  = 16,
    localparam int                      CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_lock,
    output logic              pll_reset,
    output logic              sys_reset_n,
    output logic              locked,
    output logic [NUM_CH-1:0] ce,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_val,
    output logic              div_ack,
    output logic [7:0]        relock_cnt
);

    // One shared timer serves every FSM state, so it is sized for the longest interval.
    localparam int C_T_MAX = (LOCK_TIMEOUT > LOCK_STABLE)
                           ? ((LOCK_TIMEOUT > PLL_RST_LEN) ? LOCK_TIMEOUT : PLL_RST_LEN)
                           : ((LOCK_STABLE  > PLL_RST_LEN) ? LOCK_STABLE  : PLL_RST_LEN);
    localparam int C_TMR_W = $clog2(C_T_MAX) + 1;

    localparam logic [C_TMR_W-1:0] C_RST_END = C_TMR_W'(PLL_RST_LEN - 1);
    localparam logic [C_TMR_W-1:0] C_TO_END  = C_TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [C_TMR_W-1:0] C_ST_END  = C_TMR_W'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_TMR_W-1:0]   r_timer;
    logic [C_TMR_W-1:0]   w_timer_nxt;
    logic                 w_relock_inc;
    logic [LOCK_SYNC-1:0] r_lock_sync;
    logic                 w_lock_s;
    logic                 r_run;
    logic                 w_enter_run;
    logic [NUM_CH-1:0]    w_apply;

    assign w_lock_s = r_lock_sync[LOCK_SYNC-1];

    // Synchronise the asynchronous PLL lock into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_lock_sync <= '0;
        else          r_lock_sync <= {r_lock_sync[LOCK_SYNC-2:0], pll_lock};
    end

    // Lock supervisor next-state and timer logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_relock_inc = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_timer == C_RST_END) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_TMR_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = S_STABLE;
                    w_timer_nxt = '0;
                end else if (r_timer == C_TO_END) begin
                    w_state_nxt = S_PLL_RST;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_TMR_W'(1);
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_timer_nxt = '0;
                end else if (r_timer == C_ST_END) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + C_TMR_W'(1);
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_state_nxt  = S_WAIT_LOCK;
                    w_timer_nxt  = '0;
                    w_relock_inc = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_PLL_RST;
                w_timer_nxt = '0;
            end
        endcase
    end

    // State register plus registered reset/lock outputs decoded from the next state,
    // so they line up exactly with the cycles spent in PLL_RST and RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_PLL_RST;
            r_timer    <= '0;
            pll_reset  <= 1'b1;
            r_run      <= 1'b0;
            relock_cnt <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            pll_reset <= (w_state_nxt == S_PLL_RST);
            r_run     <= (w_state_nxt == S_RUN);
            if (w_relock_inc && (relock_cnt != 8'hFF)) relock_cnt <= relock_cnt + 8'd1;
        end
    end

    assign sys_reset_n = r_run;
    assign locked      = r_run;
    assign w_enter_run = (w_state_nxt == S_RUN) && !r_run;
    assign div_ack     = |w_apply;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [DIV_W-1:0] r_cnt;
            logic [DIV_W-1:0] r_act;
            logic [DIV_W-1:0] r_pend;
            logic             r_pend_vld;
            logic             w_wr_hit;
            logic [DIV_W-1:0] w_ratio;
            logic [DIV_W-1:0] w_reload;

            assign w_wr_hit   = div_wr && (32'(div_ch) == i);
            assign ce[i]      = r_run && (r_cnt == '0);
            // A pending ratio only takes over on a strobe, so every period is
            // either wholly old or wholly new.
            assign w_apply[i] = r_pend_vld && (!r_run || ce[i]);
            assign w_ratio    = w_apply[i] ? r_pend : r_act;
            assign w_reload   = (w_ratio == '0) ? '0 : (w_ratio - DIV_W'(1));

            // Per-channel down-counter with pending/active ratio registers.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt      <= '0;
                    r_act      <= DIV_INIT[i*DIV_W +: DIV_W];
                    r_pend     <= '0;
                    r_pend_vld <= 1'b0;
                end else begin
                    if (w_wr_hit) begin
                        r_pend     <= div_val;
                        r_pend_vld <= 1'b1;
                    end else if (w_apply[i]) begin
                        r_pend_vld <= 1'b0;
                    end
                    if (w_apply[i]) r_act <= r_pend;
                    if (w_enter_run)  r_cnt <= '0;
                    else if (ce[i])   r_cnt <= w_reload;
                    else if (r_run)   r_cnt <= r_cnt - DIV_W'(1);
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire
